// File: rtl/matrix_capture_scheduler.sv
// Per-frame capture controller: arms on a frame start, decimates the active picture
// to OUT_W x OUT_H with Bresenham accumulators and issues matrix write strobes.
module matrix_capture_scheduler #(
   parameter int MAX_WIDTH  = 1920,
   parameter int MAX_HEIGHT = 1080,
   parameter int OUT_W      = 32,
   parameter int OUT_H      = 16
) (
   input  logic                            I_rgb_clk,
   input  logic                            I_rst,
   input  logic                            I_enable,
   input  logic                            I_new_frame,
   input  logic                            I_rgb_de,
   input  logic [$clog2(MAX_WIDTH)-1:0]    I_image_width,
   input  logic [$clog2(MAX_HEIGHT)-1:0]   I_image_height,
   input  logic                            I_width_valid,
   input  logic                            I_height_valid,
   input  logic                            I_buf_ready,
   output logic                            O_wr_en,
   output logic [$clog2(OUT_W)-1:0]        O_wr_x,
   output logic [$clog2(OUT_H)-1:0]        O_wr_y,
   output logic [$clog2(OUT_W*OUT_H)-1:0]  O_wr_addr,
   output logic                            O_busy,
   output logic                            O_frame_done,
   output logic                            O_frame_skip,
   output logic                            O_frame_abort,
   output logic                            O_err_size
);
   localparam int WW  = $clog2(MAX_WIDTH);
   localparam int HW  = $clog2(MAX_HEIGHT);
   localparam int XW  = $clog2(OUT_W);
   localparam int YW  = $clog2(OUT_H);
   localparam int AW  = $clog2(OUT_W*OUT_H);
   localparam int AXW = WW + 1;
   localparam int AYW = HW + 1;
   localparam int XCW = XW + 1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      CAPTURE    = 2'd2,
      DONE       = 2'd3
   } state_t;

   state_t           state_r;
   logic [WW-1:0]    w_r;
   logic [HW-1:0]    h_r;
   logic [AXW-1:0]   ax_r;
   logic [AYW-1:0]   ay_r;
   logic [XCW-1:0]   x_cnt_r;
   logic [YW-1:0]    y_cnt_r;
   logic             row_sel_r;
   logic             de_d_r;

   logic             size_ok_s, frame_start_s, in_cap_s, line_start_s, line_end_s, pix_s;
   logic [WW-1:0]    w_cur_s;
   logic [HW-1:0]    h_cur_s;
   logic [AYW-1:0]   ay_base_s, sy_s, ay_nxt_s;
   logic [AXW-1:0]   ax_base_s, sx_s, ax_nxt_s;
   logic [XCW-1:0]   xc_base_s;
   logic [YW-1:0]    y_cur_s;
   logic             row_hit_s, col_hit_s, row_cur_s, wr_s;
   logic [AW-1:0]    addr_s;

   // Frame-start cycle processes its own pixel with freshly latched sizes and cleared accumulators.
   always_comb begin
      size_ok_s     = I_width_valid & I_height_valid &
                      (I_image_width >= WW'(OUT_W)) & (I_image_height >= HW'(OUT_H));
      frame_start_s = I_new_frame & I_enable & size_ok_s & I_buf_ready &
                      ((state_r == WAIT_FRAME) | (state_r == CAPTURE));
      in_cap_s      = (state_r == CAPTURE) & ~I_new_frame;
      line_start_s  = frame_start_s | (in_cap_s & I_rgb_de & ~de_d_r);
      line_end_s    = in_cap_s & ~I_rgb_de & de_d_r & row_sel_r;
      pix_s         = I_rgb_de & (frame_start_s | in_cap_s);
      w_cur_s       = frame_start_s ? I_image_width  : w_r;
      h_cur_s       = frame_start_s ? I_image_height : h_r;
      ay_base_s     = frame_start_s ? {AYW{1'b0}} : ay_r;
      ax_base_s     = line_start_s  ? {AXW{1'b0}} : ax_r;
      xc_base_s     = line_start_s  ? {XCW{1'b0}} : x_cnt_r;
      y_cur_s       = frame_start_s ? {YW{1'b0}}  : y_cnt_r;
      sy_s          = ay_base_s + AYW'(OUT_H);
      row_hit_s     = sy_s >= {1'b0, h_cur_s};
      ay_nxt_s      = row_hit_s ? (sy_s - {1'b0, h_cur_s}) : sy_s;
      row_cur_s     = line_start_s ? row_hit_s : row_sel_r;
      sx_s          = ax_base_s + AXW'(OUT_W);
      col_hit_s     = sx_s >= {1'b0, w_cur_s};
      ax_nxt_s      = col_hit_s ? (sx_s - {1'b0, w_cur_s}) : sx_s;
      wr_s          = pix_s & row_cur_s & col_hit_s & (xc_base_s < XCW'(OUT_W));
      addr_s        = AW'(y_cur_s) * AW'(OUT_W) + AW'(xc_base_s[XW-1:0]);
   end

   // Capture FSM, decimation state and registered outputs.
   always_ff @(posedge I_rgb_clk) begin
      if (I_rst) begin
         state_r       <= IDLE;
         w_r           <= {WW{1'b0}};
         h_r           <= {HW{1'b0}};
         ax_r          <= {AXW{1'b0}};
         ay_r          <= {AYW{1'b0}};
         x_cnt_r       <= {XCW{1'b0}};
         y_cnt_r       <= {YW{1'b0}};
         row_sel_r     <= 1'b0;
         de_d_r        <= 1'b0;
         O_wr_en       <= 1'b0;
         O_wr_x        <= {XW{1'b0}};
         O_wr_y        <= {YW{1'b0}};
         O_wr_addr     <= {AW{1'b0}};
         O_busy        <= 1'b0;
         O_frame_done  <= 1'b0;
         O_frame_skip  <= 1'b0;
         O_frame_abort <= 1'b0;
         O_err_size    <= 1'b0;
      end else begin
         de_d_r        <= I_rgb_de;
         O_err_size    <= ~size_ok_s;
         O_wr_en       <= wr_s;
         O_wr_x        <= xc_base_s[XW-1:0];
         O_wr_y        <= y_cur_s;
         O_wr_addr     <= addr_s;
         O_frame_done  <= 1'b0;
         O_frame_skip  <= 1'b0;
         O_frame_abort <= 1'b0;

         if (pix_s)             ax_r <= ax_nxt_s;
         else if (line_start_s) ax_r <= {AXW{1'b0}};

         if (line_start_s) begin
            ay_r      <= ay_nxt_s;
            row_sel_r <= row_hit_s;
         end

         if (wr_s)              x_cnt_r <= xc_base_s + XCW'(1);
         else if (line_start_s) x_cnt_r <= {XCW{1'b0}};

         if (frame_start_s) begin
            w_r     <= I_image_width;
            h_r     <= I_image_height;
            y_cnt_r <= {YW{1'b0}};
         end else if (line_end_s && (y_cnt_r != YW'(OUT_H - 1))) begin
            y_cnt_r <= y_cnt_r + YW'(1);
         end

         case (state_r)
            IDLE: begin
               if (I_enable) state_r <= WAIT_FRAME;
            end
            WAIT_FRAME: begin
               if (!I_enable) begin
                  state_r <= IDLE;
               end else if (frame_start_s) begin
                  state_r <= CAPTURE;
                  O_busy  <= 1'b1;
               end else if (I_new_frame && size_ok_s && !I_buf_ready) begin
                  O_frame_skip <= 1'b1;
               end
            end
            CAPTURE: begin
               if (I_new_frame) begin
                  O_frame_abort <= 1'b1;
                  if (!frame_start_s) begin
                     state_r <= I_enable ? WAIT_FRAME : IDLE;
                     O_busy  <= 1'b0;
                  end
               end else if (line_end_s && (y_cnt_r == YW'(OUT_H - 1))) begin
                  state_r <= DONE;
                  O_busy  <= 1'b0;
               end
            end
            DONE: begin
               O_frame_done <= 1'b1;
               state_r      <= I_enable ? WAIT_FRAME : IDLE;
            end
            default: begin
               state_r <= IDLE;
               O_busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_matrix_capture_scheduler.sv
// Directed bench for matrix_capture_scheduler: frame-level stimulus with hand-derived
// write patterns, pulse counts and boundary cases.
module tb_matrix_capture_scheduler;
   logic        clk = 1'b0;
   logic        rst, enable, new_frame, rgb_de, width_valid, height_valid, buf_ready;
   logic [10:0] image_width, image_height;
   logic        wr_en, busy, frame_done, frame_skip, frame_abort, err_size;
   logic [4:0]  wr_x;
   logic [3:0]  wr_y;
   logic [8:0]  wr_addr;

   int n_checks = 0;
   int n_pass   = 0;
   int mode, f_wr, line_wr, tot_wr, bad, done_cnt, skip_cnt, abort_cnt, busy_cnt;
   int last_addr, first_after_abort;
   bit expect_on, abort_seen, first_taken;

   always #5 clk = ~clk;

   matrix_capture_scheduler dut (
      .I_rgb_clk(clk), .I_rst(rst), .I_enable(enable), .I_new_frame(new_frame),
      .I_rgb_de(rgb_de), .I_image_width(image_width), .I_image_height(image_height),
      .I_width_valid(width_valid), .I_height_valid(height_valid), .I_buf_ready(buf_ready),
      .O_wr_en(wr_en), .O_wr_x(wr_x), .O_wr_y(wr_y), .O_wr_addr(wr_addr), .O_busy(busy),
      .O_frame_done(frame_done), .O_frame_skip(frame_skip), .O_frame_abort(frame_abort),
      .O_err_size(err_size)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // mode 0: 64x32 -> odd pixels on odd lines; mode 1: W=48,H=16 -> p%3 != 0 on every line
   function automatic bit exp_hit(input int p, input int l);
      if (mode == 0) return (p % 2 == 1) && (l % 2 == 1);
      else           return (p % 3 != 0);
   endfunction

   task automatic clear_stats();
      f_wr = 0; line_wr = 0; tot_wr = 0; bad = 0; done_cnt = 0; skip_cnt = 0;
      abort_cnt = 0; busy_cnt = 0; last_addr = -1; first_after_abort = -1;
      abort_seen = 0; first_taken = 0;
   endtask

   task automatic step(input logic de, input logic nf, input int p, input int l);
      rgb_de = de; new_frame = nf;
      @(posedge clk); #1;
      if (nf) f_wr = 0;
      if (de && p == 0) line_wr = 0;
      if (frame_done)  done_cnt++;
      if (frame_skip)  skip_cnt++;
      if (frame_abort) begin abort_cnt++; abort_seen = 1; end
      if (busy)        busy_cnt++;
      if (wr_en) begin
         if (!(de && exp_hit(p, l))) bad++;
         if (int'(wr_addr) != f_wr)      bad++;
         if (int'(wr_x) != line_wr)      bad++;
         if (int'(wr_y) != f_wr / 32)    bad++;
         if (abort_seen && !first_taken) begin first_after_abort = int'(wr_addr); first_taken = 1; end
         last_addr = int'(wr_addr);
         f_wr++; line_wr++; tot_wr++;
      end else if (expect_on && de && exp_hit(p, l)) begin
         bad++;
      end
      new_frame = 1'b0;
   endtask

   task automatic send_lines(input int w, input int l0, input int l1, input bit nf_first);
      for (int l = l0; l < l1; l++) begin
         for (int p = 0; p < w; p++) step(1'b1, nf_first && (l == l0) && (p == 0), p, l);
         step(1'b0, 1'b0, 0, l);
         step(1'b0, 1'b0, 0, l);
      end
   endtask

   task automatic vblank(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; new_frame = 1'b0; rgb_de = 1'b0;
      image_width = 11'd0; image_height = 11'd0; width_valid = 1'b0; height_valid = 1'b0;
      buf_ready = 1'b0; mode = 0; expect_on = 0;
      clear_stats();

      step(1'b0, 1'b0, 0, 0);
      check_val("reset_outputs", {wr_en, wr_x, wr_y, wr_addr, busy, frame_done,
                                  frame_skip, frame_abort, err_size}, 32'd0);
      rst = 1'b0;
      step(1'b0, 1'b0, 0, 0);
      check_val("err_invalid_size", err_size, 1);

      // 64x32 full frame
      image_width = 11'd64; image_height = 11'd32; width_valid = 1'b1; height_valid = 1'b1;
      buf_ready = 1'b1; enable = 1'b1;
      vblank(3);
      check_val("err_ok_size", err_size, 0);
      check_val("busy_idle", busy, 0);
      clear_stats(); mode = 0; expect_on = 1;
      send_lines(64, 0, 32, 1'b1);
      vblank(4);
      check_val("f64_writes", tot_wr, 512);
      check_val("f64_pattern_bad", bad, 0);
      check_val("f64_done", done_cnt, 1);
      check_val("f64_last_addr", last_addr, 511);
      check_val("f64_busy_seen", busy_cnt > 0, 1);
      check_val("f64_busy_after", busy, 0);

      // W=48, H=16: two of every three pixels, every line
      image_width = 11'd48; image_height = 11'd16;
      vblank(2);
      clear_stats(); mode = 1; expect_on = 1;
      send_lines(48, 0, 16, 1'b1);
      vblank(4);
      check_val("f48_writes", tot_wr, 512);
      check_val("f48_pattern_bad", bad, 0);
      check_val("f48_done", done_cnt, 1);

      // width below OUT_W
      image_width = 11'd16;
      vblank(2);
      check_val("w16_err", err_size, 1);
      clear_stats(); expect_on = 0;
      send_lines(16, 0, 16, 1'b1);
      vblank(4);
      check_val("w16_writes", tot_wr, 0);
      check_val("w16_skip", skip_cnt, 0);
      check_val("w16_busy", busy_cnt, 0);
      check_val("w16_done", done_cnt, 0);

      // back buffer busy on frame 1, free on frame 2
      image_width = 11'd64; image_height = 11'd32; buf_ready = 1'b0; mode = 0;
      vblank(2);
      clear_stats(); expect_on = 0;
      send_lines(64, 0, 32, 1'b1);
      vblank(2);
      check_val("skip_pulse", skip_cnt, 1);
      check_val("skip_writes", tot_wr, 0);
      buf_ready = 1'b1;
      clear_stats(); expect_on = 1;
      send_lines(64, 0, 32, 1'b1);
      vblank(4);
      check_val("skip_f2_writes", tot_wr, 512);
      check_val("skip_f2_done", done_cnt, 1);
      check_val("skip_f2_bad", bad, 0);

      // abort after 5 selected lines
      clear_stats(); expect_on = 1;
      send_lines(64, 0, 10, 1'b1);
      check_val("abort_pre_writes", tot_wr, 160);
      check_val("abort_pre_pulse", abort_cnt, 0);
      clear_stats();
      send_lines(64, 0, 32, 1'b1);
      vblank(4);
      check_val("abort_pulse", abort_cnt, 1);
      check_val("abort_restart_addr", first_after_abort, 0);
      check_val("abort_f2_writes", tot_wr, 512);
      check_val("abort_f2_done", done_cnt, 1);
      check_val("abort_f2_bad", bad, 0);

      // reset in the middle of a capture
      clear_stats(); expect_on = 1;
      send_lines(64, 0, 4, 1'b1);
      check_val("rst_pre_writes", tot_wr, 64);
      rst = 1'b1;
      step(1'b0, 1'b0, 0, 4);
      check_val("rst_mid_outputs", {wr_en, wr_x, wr_y, wr_addr, busy, frame_done,
                                    frame_skip, frame_abort, err_size}, 32'd0);
      rst = 1'b0;
      clear_stats(); expect_on = 0;
      send_lines(64, 4, 32, 1'b0);
      vblank(4);
      check_val("rst_post_writes", tot_wr, 0);
      check_val("rst_post_done", done_cnt, 0);
      check_val("rst_post_busy", busy_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
